// File: rtl/lsu_pkg.sv
// Shared LSU parameters and the store-side line-scatter state encoding.
package lsu_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 8;
  localparam int IDX_W     = $clog2(NUM_WORDS);

  typedef enum logic {
    SCAT_FILL  = 1'b0,
    SCAT_DRAIN = 1'b1
  } scatter_state_e;

endpackage

// File: rtl/demux_1to8.sv
// Word-index to per-word byte-enable decoder; the store-side inverse of the 8-to-1 read mux.
module demux_1to8
  import lsu_pkg::*;
#(
  parameter int NUM_WORDS = lsu_pkg::NUM_WORDS,
  parameter int IDX_W     = lsu_pkg::IDX_W,
  parameter int BE_W      = lsu_pkg::WORD_W / 8
) (
  input  logic                      en_i,
  input  logic [IDX_W-1:0]          sel_i,
  input  logic [BE_W-1:0]           be_i,
  output logic [NUM_WORDS*BE_W-1:0] word_be_o
);

  always_comb begin
    word_be_o = '0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      if (en_i && (sel_i == IDX_W'(w))) begin
        word_be_o[w*BE_W +: BE_W] = be_i;
      end
    end
  end

endmodule

// File: rtl/lsu_line_scatter.sv
// Merges byte-enabled store words into a line buffer and hands the assembled
// line to the memory side once every byte is written or on flush.
module lsu_line_scatter
  import lsu_pkg::*;
#(
  parameter int WORD_W    = lsu_pkg::WORD_W,
  parameter int NUM_WORDS = lsu_pkg::NUM_WORDS,
  parameter int IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             wr_valid_i,
  output logic                             wr_ready_o,
  input  logic [IDX_W-1:0]                 wr_sel_i,
  input  logic [WORD_W-1:0]                wr_data_i,
  input  logic [WORD_W/8-1:0]              wr_be_i,
  input  logic                             flush_i,
  output logic                             line_valid_o,
  input  logic                             line_ready_i,
  output logic [NUM_WORDS*WORD_W-1:0]      line_data_o,
  output logic [NUM_WORDS*WORD_W/8-1:0]    line_be_o,
  output logic                             busy_o
);

  localparam int BE_W   = WORD_W / 8;
  localparam int LINE_B = NUM_WORDS * BE_W;

  scatter_state_e            state_q, state_d;
  logic [NUM_WORDS*WORD_W-1:0] buf_q, buf_d;
  logic [LINE_B-1:0]         mask_q, mask_d;
  logic [LINE_B-1:0]         byte_we;
  logic                      wr_acc;
  logic                      drain_hs;

  assign wr_acc   = (state_q == SCAT_FILL) && wr_valid_i;
  assign drain_hs = (state_q == SCAT_DRAIN) && line_ready_i;

  demux_1to8 #(
    .NUM_WORDS (NUM_WORDS),
    .IDX_W     (IDX_W),
    .BE_W      (BE_W)
  ) u_demux (
    .en_i      (wr_acc),
    .sel_i     (wr_sel_i),
    .be_i      (wr_be_i),
    .word_be_o (byte_we)
  );

  // Byte merge; the handshake clear cannot coincide with a write since writes only land in FILL.
  always_comb begin
    buf_d  = buf_q;
    mask_d = mask_q | byte_we;
    if (drain_hs) begin
      buf_d  = '0;
      mask_d = '0;
    end else begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        for (int b = 0; b < BE_W; b++) begin
          if (byte_we[w*BE_W + b]) begin
            buf_d[(w*BE_W + b)*8 +: 8] = wr_data_i[b*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= SCAT_FILL;
      buf_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      mask_q  <= mask_d;
    end
  end

  // Full/flush test looks at the post-merge mask so a same-cycle write is included.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAT_FILL: begin
        if ((&mask_d) || (flush_i && (|mask_d))) state_d = SCAT_DRAIN;
      end
      SCAT_DRAIN: begin
        if (line_ready_i) state_d = SCAT_FILL;
      end
      default: state_d = SCAT_FILL;
    endcase
  end

  always_comb begin
    wr_ready_o   = (state_q == SCAT_FILL);
    line_valid_o = (state_q == SCAT_DRAIN);
    busy_o       = (|mask_q) || (state_q == SCAT_DRAIN);
    line_data_o  = buf_q;
    line_be_o    = mask_q;
  end

endmodule

// File: tb/tb_lsu_line_scatter.sv
// Scoreboard bench for lsu_line_scatter: a reference line model predicts each
// emitted line, which is compared when the DUT drains it.
module tb_lsu_line_scatter;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 8;
  localparam int IDX_W     = 3;
  localparam int BE_W      = WORD_W / 8;

  typedef struct {
    logic [NUM_WORDS*WORD_W-1:0] data;
    logic [NUM_WORDS*BE_W-1:0]   be;
  } line_t;

  logic                        clk_i = 1'b0;
  logic                        rst_ni;
  logic                        wr_valid_i;
  logic                        wr_ready_o;
  logic [IDX_W-1:0]            wr_sel_i;
  logic [WORD_W-1:0]           wr_data_i;
  logic [BE_W-1:0]             wr_be_i;
  logic                        flush_i;
  logic                        line_valid_o;
  logic                        line_ready_i;
  logic [NUM_WORDS*WORD_W-1:0] line_data_o;
  logic [NUM_WORDS*BE_W-1:0]   line_be_o;
  logic                        busy_o;

  int n_chk  = 0;
  int n_fail = 0;

  line_t sb_q[$];
  logic [WORD_W-1:0] m_data [NUM_WORDS];
  logic [BE_W-1:0]   m_be   [NUM_WORDS];
  bit                m_drain;

  always #5 clk_i = ~clk_i;

  lsu_line_scatter dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .wr_valid_i   (wr_valid_i),
    .wr_ready_o   (wr_ready_o),
    .wr_sel_i     (wr_sel_i),
    .wr_data_i    (wr_data_i),
    .wr_be_i      (wr_be_i),
    .flush_i      (flush_i),
    .line_valid_o (line_valid_o),
    .line_ready_i (line_ready_i),
    .line_data_o  (line_data_o),
    .line_be_o    (line_be_o),
    .busy_o       (busy_o)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic line_t model_line();
    line_t l;
    for (int w = 0; w < NUM_WORDS; w++) begin
      l.data[w*WORD_W +: WORD_W] = m_data[w];
      l.be[w*BE_W +: BE_W]       = m_be[w];
    end
    return l;
  endfunction

  task automatic model_clear();
    for (int w = 0; w < NUM_WORDS; w++) begin
      m_data[w] = '0;
      m_be[w]   = '0;
    end
    m_drain = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference behaviour of one cycle in FILL with an optional write and flush.
  task automatic model_cycle(input bit v, input logic [IDX_W-1:0] sel,
                             input logic [WORD_W-1:0] d, input logic [BE_W-1:0] be,
                             input bit fl);
    bit full, any;
    if (m_drain) return;
    if (v) begin
      for (int b = 0; b < BE_W; b++)
        if (be[b]) m_data[sel][b*8 +: 8] = d[b*8 +: 8];
      m_be[sel] = m_be[sel] | be;
    end
    full = 1'b1;
    any  = 1'b0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      if (m_be[w] != '1) full = 1'b0;
      if (m_be[w] != '0) any  = 1'b1;
    end
    if (full || (fl && any)) begin
      sb_q.push_back(model_line());
      m_drain = 1'b1;
    end
  endtask

  task automatic drive(input bit v, input logic [IDX_W-1:0] sel,
                       input logic [WORD_W-1:0] d, input logic [BE_W-1:0] be,
                       input bit fl);
    wr_valid_i = v;
    wr_sel_i   = sel;
    wr_data_i  = d;
    wr_be_i    = be;
    flush_i    = fl;
    model_cycle(v, sel, d, be, fl);
    tick();
    wr_valid_i = 1'b0;
    flush_i    = 1'b0;
    wr_be_i    = '0;
  endtask

  // Waits (bounded) for a line, compares it with the scoreboard head and takes it.
  task automatic take_line(input string tag);
    line_t exp;
    int    waited;
    waited = 0;
    while (!line_valid_o && waited < 20) begin
      tick();
      waited++;
    end
    chk({tag, "_valid"}, line_valid_o, 1'b1);
    if (!line_valid_o) return;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 1'b0, 1'b1);
      return;
    end
    exp = sb_q.pop_front();
    chk({tag, "_data"}, line_data_o, exp.data);
    chk({tag, "_be"}, line_be_o, exp.be);
    chk({tag, "_wr_ready_low"}, wr_ready_o, 1'b0);
    line_ready_i = 1'b1;
    tick();
    line_ready_i = 1'b0;
    model_clear();
    chk({tag, "_post_valid"}, line_valid_o, 1'b0);
    chk({tag, "_post_ready"}, wr_ready_o, 1'b1);
    chk({tag, "_post_be"}, line_be_o, '0);
    chk({tag, "_post_data"}, line_data_o, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_ready"}, wr_ready_o, 1'b1);
    chk({tag, "_line_valid"}, line_valid_o, 1'b0);
    chk({tag, "_data"}, line_data_o, '0);
    chk({tag, "_be"}, line_be_o, '0);
    chk({tag, "_busy"}, busy_o, 1'b0);
  endtask

  initial begin
    logic [NUM_WORDS*WORD_W-1:0] held_data;
    logic [NUM_WORDS*BE_W-1:0]   held_be;
    rst_ni = 1'b0; wr_valid_i = 1'b0; wr_sel_i = '0; wr_data_i = '0;
    wr_be_i = '0; flush_i = 1'b0; line_ready_i = 1'b0;
    model_clear();
    tick(); tick();
    rst_ni = 1'b1;
    check_reset_outputs("reset");

    // Full line
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (i == NUM_WORDS - 1) chk("full_not_early", line_valid_o, 1'b0);
      drive(1'b1, IDX_W'(i), 32'h1000_0000 + i, 4'hF, 1'b0);
    end
    chk("full_valid_rise", line_valid_o, 1'b1);
    chk("full_word5", line_data_o[5*WORD_W +: WORD_W], 32'h1000_0005);
    chk("full_be_ones", line_be_o, {NUM_WORDS*BE_W{1'b1}});
    chk("full_busy", busy_o, 1'b1);
    tick();
    chk("full_hold_ready", wr_ready_o, 1'b0);
    take_line("full");

    // Byte merge with flush on the second write
    drive(1'b1, 3'd2, 32'hAABBCCDD, 4'b0011, 1'b0);
    chk("merge_busy", busy_o, 1'b1);
    chk("merge_not_valid", line_valid_o, 1'b0);
    drive(1'b1, 3'd2, 32'h11223344, 4'b1100, 1'b1);
    chk("merge_word2", line_data_o[2*WORD_W +: WORD_W], 32'h1122CCDD);
    chk("merge_be", line_be_o, 32'h0000_0F00);
    take_line("merge");

    // Empty flush
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, '0, '0, 1'b1);
      chk("empty_flush_valid", line_valid_o, 1'b0);
      chk("empty_flush_busy", busy_o, 1'b0);
    end
    chk("empty_flush_sb", sb_q.size(), 0);

    // be=0 write is accepted without effect
    drive(1'b1, 3'd4, 32'hDEADBEEF, 4'h0, 1'b1);
    chk("be0_no_effect", line_be_o, '0);
    chk("be0_no_valid", line_valid_o, 1'b0);

    // Backpressure
    for (int i = 0; i < NUM_WORDS; i++)
      drive(1'b1, IDX_W'(i), $urandom, 4'hF, 1'b0);
    held_data = line_data_o;
    held_be   = line_be_o;
    wr_valid_i = 1'b1; wr_sel_i = 3'd0; wr_data_i = 32'h5555_AAAA; wr_be_i = 4'h1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", line_valid_o, 1'b1);
      chk("bp_data_stable", line_data_o, held_data);
      chk("bp_be_stable", line_be_o, held_be);
      chk("bp_no_accept", wr_ready_o, 1'b0);
    end
    chk("bp_sb_data", held_data, sb_q[0].data);
    void'(sb_q.pop_front());
    line_ready_i = 1'b1;
    tick();
    line_ready_i = 1'b0;
    model_clear();
    chk("bp_mask_clear", line_be_o, '0);
    chk("bp_ready_back", wr_ready_o, 1'b1);
    model_cycle(1'b1, 3'd0, 32'h5555_AAAA, 4'h1, 1'b0);
    tick();
    wr_valid_i = 1'b0; wr_be_i = '0;
    chk("bp_next_accept_be", line_be_o, 32'h0000_0001);
    chk("bp_next_accept_data", line_data_o[7:0], 8'hAA);
    drive(1'b0, '0, '0, '0, 1'b1);
    take_line("bp_tail");

    // Random partial lines, flushed on the last write
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 6; i++)
        drive(1'b1, IDX_W'($urandom_range(0, NUM_WORDS-1)), $urandom,
              BE_W'($urandom_range(1, 15)), (i == 5));
      take_line("rand");
    end

    // Overwrite, then reset while draining
    drive(1'b1, 3'd7, 32'hAAAA_0001, 4'hF, 1'b0);
    drive(1'b1, 3'd7, 32'hBBBB_0002, 4'hF, 1'b0);
    chk("ovw_word7", line_data_o[7*WORD_W +: WORD_W], 32'hBBBB_0002);
    drive(1'b0, '0, '0, '0, 1'b1);
    chk("ovw_drain", line_valid_o, 1'b1);
    chk("ovw_sb_word7", sb_q[0].data[7*WORD_W +: WORD_W], line_data_o[7*WORD_W +: WORD_W]);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    void'(sb_q.pop_front());
    model_clear();
    check_reset_outputs("rst_in_drain");

    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_line_scatter.md
# lsu_line_scatter

Store-side counterpart of the LSU's 8-to-1 word read mux. Accepts single 32-bit store words with a 3-bit word index and byte enables, scatters/merges them into an 8-word line buffer, and emits the assembled line with its byte mask to the memory side via valid/ready. A line is emitted when every byte is written or on an explicit flush.

## Interface
- `WORD_W`, default 32: word width in bits; a multiple of 8.
- `NUM_WORDS`, default 8: words per line; a power of 2.
- `IDX_W`, default `$clog2(NUM_WORDS)` = 3: word-index width.
- `clk_i  in  1`: clock; all state changes on the rising edge.
- `rst_ni  in  1`: reset, synchronous and active-low.
- `wr_valid_i  in  1`: store word offered.
- `wr_ready_o  out  1`: store word accepted this cycle when high together with `wr_valid_i`.
- `wr_sel_i  in  IDX_W`: target word index.
- `wr_data_i  in  WORD_W`: store data.
- `wr_be_i  in  WORD_W/8`: byte enables; bit b covers `wr_data_i[8b+7:8b]`.
- `flush_i  in  1`: emit the current partial line.
- `line_valid_o  out  1`: assembled line available.
- `line_ready_i  in  1`: consumer takes the line.
- `line_data_o  out  NUM_WORDS*WORD_W`: line data; word i at bits `[i*WORD_W +: WORD_W]`.
- `line_be_o  out  NUM_WORDS*WORD_W/8`: accumulated byte mask, indexed the same way.
- `busy_o  out  1`: high when the byte mask is non-zero or the FSM is in DRAIN.

## Operation
- **FSM states:**
  - **FILL:** `wr_ready_o`=1, `line_valid_o`=0.
  - **DRAIN:** `wr_ready_o`=0, `line_valid_o`=1.
- **Write accept** (FILL and `wr_valid_i`):
  - For each set bit b of `wr_be_i`, byte b of `buf[wr_sel_i]` is loaded from `wr_data_i`.
  - `mask[wr_sel_i]` |= `wr_be_i`.
  - Bytes whose enable is clear are left unchanged.
  - Rewriting a byte overwrites it; the last write wins.
  - `wr_be_i`=0 is accepted and has no effect.
- **FILL → DRAIN** when either holds after the current write is merged:
  - the mask is all ones; or
  - `flush_i`=1 and the mask is non-zero.
- **Flush corner cases:**
  - Write and flush in the same cycle: the write is merged first, and the drained line includes it.
  - Flush with an empty mask and no write: ignored; the FSM stays in FILL.
- **DRAIN:**
  - `line_data_o` and `line_be_o` are held stable until `line_valid_o && line_ready_i`.
  - On that handshake: data and mask are cleared to 0 and the FSM returns to FILL.
  - `flush_i` in DRAIN is ignored.
  - `wr_valid_i` in DRAIN is not accepted; the producer holds its word.
- **Output source:** `line_data_o` and `line_be_o` always show the buffer contents, in FILL as well, but are meaningful only while `line_valid_o`=1.

## Timing
- **Reset** (`rst_ni`=0 at the edge): FSM=FILL, buffer=0, mask=0.
  - Outputs after that edge: `wr_ready_o`=1, `line_valid_o`=0, `line_data_o`=0, `line_be_o`=0, `busy_o`=0.
  - Reset in DRAIN drops the pending line.
- **Write latency:** a write accepted at edge N is visible on `line_data_o`/`line_be_o` after edge N.
- **Drain latency:** the write that completes the mask, or the flush, is sampled at edge N; `line_valid_o` rises after edge N.
- **Drain handshake:** sampled at edge M; `line_valid_o`=0 and `wr_ready_o`=1 after edge M.
  - There is no same-cycle refill.
  - Minimum period for full-line traffic: NUM_WORDS+1 cycles per line.
- `wr_ready_o` and `line_valid_o` are decoded from registered state only; there is no combinational path from `line_ready_i` or `wr_valid_i`.

## Structure
- **Shared package `lsu_pkg`:** `WORD_W`, `NUM_WORDS`, `IDX_W`, and the enum `scatter_state_e` {`SCAT_FILL`, `SCAT_DRAIN`}.
- **Sub-module `demux_1to8`:** a combinational index-to-one-hot word-enable decoder, the inverse of the read mux. It is gated by the write accept and ANDed with `wr_be_i` per word.
- **Top level:** the buffer registers, the mask registers, and the FSM.

## Test plan
- **Full line:** after reset, write words 0..7 with be=F, data=32'h1000_0000+i, `line_ready_i`=0.
  - `line_valid_o` rises the cycle after word 7.
  - `line_be_o` is all ones; word 5 reads 32'h1000_0005.
  - `wr_ready_o`=0 while held.
- **Byte merge + flush:** write sel=2 data=32'hAABBCCDD be=4'b0011, then sel=2 data=32'h11223344 be=4'b1100 together with `flush_i`.
  - Emitted word 2 = 32'h1122CCDD.
  - Mask word 2 = 4'hF; all other mask words 0.
- **Empty flush:** `flush_i`=1 with an empty mask and no write.
  - `line_valid_o` stays 0 and `busy_o` stays 0.
- **Backpressure:** hold `line_ready_i`=0 for 5 cycles while `wr_valid_i`=1.
  - Outputs are stable and no write is accepted.
  - After `line_ready_i`=1 for one cycle: mask=0, and the next write is accepted one cycle later.
- **Overwrite and reset:**
  - Write sel=7 twice (data A then B, be=F); word 7=B.
  - Assert `rst_ni`=0 for one cycle while in DRAIN: all outputs return to their reset values.
